// File: rtl/od_line_repeater.sv
// od_line_repeater: per-line open-drain direction-latching repeater; define OD_REPEATER_TIMEOUT_EN for stuck-low timeout
module od_line_repeater #(
    parameter int NUM_LINES      = 2,
    parameter int FILTER_CYCLES  = 2,
    parameter int HOLDOFF_CYCLES = 15,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 ICE_CLK,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_LINES-1:0] a_di,
    input  logic [NUM_LINES-1:0] b_di,
    output logic [NUM_LINES-1:0] a_oe,
    output logic [NUM_LINES-1:0] b_oe,
    output logic [NUM_LINES-1:0] dir_a2b,
    output logic [NUM_LINES-1:0] dir_b2a,
    output logic [NUM_LINES-1:0] stuck,
    input  logic                 stuck_clr
);
    localparam int N2 = 2 * NUM_LINES;
    localparam int FW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
`ifdef OD_REPEATER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        A_DRIVES,
        B_DRIVES,
`ifdef OD_REPEATER_TIMEOUT_EN
        HOLDOFF,
        STUCK
`else
        HOLDOFF
`endif
    } state_t;

    // channel i < NUM_LINES is side A line i, the rest are side B
    logic [N2-1:0] s1_q, s2_q, filt_q, filt_d;
    logic [FW-1:0] fcnt_q [N2];
    logic [FW-1:0] fcnt_d [N2];

    // two-flop synchronisers, reset to the released (high) level
    always_ff @(posedge ICE_CLK) begin
        if (rst) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= {b_di, a_di};
            s2_q <= s1_q;
        end
    end

    // accept a new level on the sample that follows FILTER_CYCLES disagreeing ones
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < N2; i++) begin
            filt_d[i] = (s2_q[i] != filt_q[i] && fcnt_q[i] == FW'(FILTER_CYCLES)) ? s2_q[i] : filt_q[i];
            fcnt_d[i] = (s2_q[i] == filt_q[i] || filt_d[i] != filt_q[i]) ? '0 : fcnt_q[i] + 1'b1;
        end
    end

    // filter level and run-length registers
    always_ff @(posedge ICE_CLK) begin
        if (rst) begin
            filt_q <= '1;
            fcnt_q <= '{default: '0};
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        state_t        st_q, st_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          a_oe_q, b_oe_q;
        logic          fa, fb;
        assign fa = filt_d[l];
        assign fb = filt_d[NUM_LINES + l];
`ifdef OD_REPEATER_TIMEOUT_EN
        logic [TW-1:0] tcnt_q, tcnt_d;
        logic          src_a_q, src_a_d, stuck_q, stuck_d;
`endif

        // latch direction on the first side to go low, release into holdoff
        always_comb begin
            st_d   = st_q;
            hcnt_d = hcnt_q;
`ifdef OD_REPEATER_TIMEOUT_EN
            tcnt_d  = tcnt_q;
            src_a_d = src_a_q;
`endif
            case (st_q)
                IDLE: begin
                    st_d = !fa ? A_DRIVES : !fb ? B_DRIVES : IDLE;
`ifdef OD_REPEATER_TIMEOUT_EN
                    tcnt_d  = '0;
                    src_a_d = !fa;
`endif
                end
                A_DRIVES, B_DRIVES: begin
                    if (st_q == A_DRIVES ? fa : fb) begin
                        st_d   = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
                        hcnt_d = HW'(HOLDOFF_CYCLES);
                    end
`ifdef OD_REPEATER_TIMEOUT_EN
                    else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1))
                        st_d = STUCK;
                    else
                        tcnt_d = tcnt_q + 1'b1;
`endif
                end
                HOLDOFF: begin
                    st_d   = (hcnt_q == '0) ? IDLE : HOLDOFF;
                    hcnt_d = (hcnt_q == '0) ? '0 : hcnt_q - 1'b1;
                end
`ifdef OD_REPEATER_TIMEOUT_EN
                STUCK: begin
                    if (src_a_q ? fa : fb) begin
                        st_d   = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
                        hcnt_d = HW'(HOLDOFF_CYCLES);
                    end
                end
`endif
                default: st_d = IDLE;
            endcase
            if (!enable) begin
                st_d   = IDLE;
                hcnt_d = '0;
`ifdef OD_REPEATER_TIMEOUT_EN
                tcnt_d = '0;
`endif
            end
`ifdef OD_REPEATER_TIMEOUT_EN
            stuck_d = (stuck_clr ? 1'b0 : stuck_q) | (st_d == STUCK && st_q != STUCK);
`endif
        end

        // state, counters and pin enables registered from the next state
        always_ff @(posedge ICE_CLK) begin
            if (rst) begin
                st_q   <= IDLE;
                hcnt_q <= '0;
                a_oe_q <= 1'b0;
                b_oe_q <= 1'b0;
`ifdef OD_REPEATER_TIMEOUT_EN
                tcnt_q  <= '0;
                src_a_q <= 1'b0;
                stuck_q <= 1'b0;
`endif
            end else begin
                st_q   <= st_d;
                hcnt_q <= hcnt_d;
                a_oe_q <= st_d == B_DRIVES;
                b_oe_q <= st_d == A_DRIVES;
`ifdef OD_REPEATER_TIMEOUT_EN
                tcnt_q  <= tcnt_d;
                src_a_q <= src_a_d;
                stuck_q <= stuck_d;
`endif
            end
        end

        assign a_oe[l]    = a_oe_q;
        assign b_oe[l]    = b_oe_q;
        assign dir_a2b[l] = st_q == A_DRIVES;
        assign dir_b2a[l] = st_q == B_DRIVES;
`ifdef OD_REPEATER_TIMEOUT_EN
        assign stuck[l] = stuck_q;
`else
        assign stuck[l] = 1'b0;
`endif
    end

`ifndef OD_REPEATER_TIMEOUT_EN
    logic unused_stuck_clr;
    assign unused_stuck_clr = stuck_clr;
`endif
endmodule
